// File: rtl/encode_mul_arb.sv
// encode_mul_arb: round-robin arbiter feeding one shared pipelined signed x unsigned multiplier.
// Ports (encode_mul_arb):
//   clk, reset      - clock, asynchronous active-high reset
//   en              - grant enable; in-flight ops still drain while low
//   req_valid/req_a/req_b/req_ready - per-requester operands and one-hot grant
//   rsp_valid/rsp_data - one-hot result strobe and 31-bit signed product
//   busy, inflight  - activity flag and count of accepted-but-unreturned ops
// Ports (encode_mul_mul_16s_15ns_31_4_1):
//   clk, ce, din0 (signed 16), din1 (unsigned 15), dout (signed 31) after 3 edges

module encode_mul_mul_16s_15ns_31_4_1 (
    input  logic        clk,
    input  logic        ce,
    input  logic [15:0] din0,
    input  logic [14:0] din1,
    output logic [30:0] dout
);
    logic [15:0] a_r;
    logic [14:0] b_r;
    logic [30:0] p_r;
    logic signed [31:0] prod;

    // din1 is zero-extended so it multiplies as an unsigned operand
    assign prod = $signed(a_r) * $signed({1'b0, b_r});

    always_ff @(posedge clk) begin
        if (ce) begin
            a_r  <= din0;
            b_r  <= din1;
            p_r  <= prod[30:0];
            dout <= p_r;
        end
    end
endmodule

module encode_mul_arb #(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [15*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [30:0]       rsp_data,
    output logic              busy,
    output logic [2:0]        inflight
);
    logic [1:0]  ptr, gnt_idx;
    logic        gnt;
    logic [2:0]  idx;
    logic [3:0]  v_pad;
    logic [63:0] a_pad;
    logic [59:0] b_pad;
    logic [15:0] mul_a;
    logic [14:0] mul_b;
    logic [30:0] mul_p;
    logic [2:0]  sv;
    logic [1:0]  sid [0:2];

    // Padding to the 4-requester maximum keeps every variable index in range
    assign v_pad = 4'(req_valid);
    assign a_pad = 64'(req_a);
    assign b_pad = 60'(req_b);

    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = 3'(ptr) + 3'(k);
            idx = (idx >= 3'(NREQ)) ? idx - 3'(NREQ) : idx;
            if (!gnt && en && v_pad[idx[1:0]]) begin
                gnt     = 1'b1;
                gnt_idx = idx[1:0];
            end
        end
    end

    assign req_ready = gnt ? NREQ'(1) << gnt_idx : '0;
    assign mul_a     = gnt ? a_pad[16*gnt_idx +: 16] : '0;
    assign mul_b     = gnt ? b_pad[15*gnt_idx +: 15] : '0;
    assign busy      = inflight != 3'd0;

    encode_mul_mul_16s_15ns_31_4_1 u_mul (
        .clk  (clk),
        .ce   (1'b1),
        .din0 (mul_a),
        .din1 (mul_b),
        .dout (mul_p)
    );

    // Tracking valids are reset so ops in flight at reset never produce a result,
    // even though the multiplier's data registers keep whatever they held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            sv        <= '0;
            sid[0]    <= '0;
            sid[1]    <= '0;
            sid[2]    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            inflight  <= '0;
        end else begin
            sv        <= {sv[1:0], gnt};
            sid[0]    <= gnt_idx;
            sid[1]    <= sid[0];
            sid[2]    <= sid[1];
            if (gnt)
                ptr <= (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
            rsp_valid <= sv[2] ? NREQ'(1) << sid[2] : '0;
            if (sv[2])
                rsp_data <= mul_p;
            // an op stays counted through the cycle its rsp_valid is shown
            inflight  <= inflight + 3'(gnt) - 3'(|rsp_valid);
        end
    end
endmodule

// File: tb/tb_encode_mul_arb.sv
// tb_encode_mul_arb: directed self-checking bench for encode_mul_arb (NREQ=2 and NREQ=3).
module tb_encode_mul_arb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  v = '0;
    logic signed [15:0] a0 = '0, a1 = '0;
    logic [14:0] b0 = '0, b1 = '0;
    logic [31:0] req_a;
    logic [29:0] req_b;
    logic [1:0]  ready, rsp_valid;
    logic [30:0] rsp_data;
    logic        busy;
    logic [2:0]  inflight;

    logic [2:0]  v3 = '0;
    logic [47:0] a3 = '0;
    logic [44:0] b3 = '0;
    logic [2:0]  ready3, rsp_valid3;
    logic [30:0] rsp_data3;
    logic        busy3;
    logic [2:0]  inflight3;

    int checks = 0;
    int failures = 0;
    int exp_id [0:7];
    int exp_p  [0:7];

    assign req_a = {a1, a0};
    assign req_b = {b1, b0};

    always #5 clk = ~clk;

    encode_mul_arb #(.NREQ(2)) dut (
        .clk(clk), .reset(reset), .en(en), .req_valid(v), .req_a(req_a), .req_b(req_b),
        .req_ready(ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .inflight(inflight)
    );

    encode_mul_arb #(.NREQ(3)) dut3 (
        .clk(clk), .reset(reset), .en(1'b1), .req_valid(v3), .req_a(a3), .req_b(b3),
        .req_ready(ready3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy(busy3), .inflight(inflight3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [30:0] d);
        return {d[30], d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b0;
        v = '0;
        v3 = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_busy", 32'(busy), 0);
        do_reset();

        // single op: -3 * 5, grant in first cycle after reset
        en = 1'b1; v = 2'b01; a0 = -16'sd3; b0 = 15'd5;
        @(negedge clk);
        chk("t1_ready", 32'(ready), 1);
        step();
        v = '0;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            chk("t1_no_rsp", 32'(rsp_valid), 0);
            chk("t1_inflight", 32'(inflight), 1);
            step();
        end
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_rsp_data", sx(rsp_data), -15);
        step();
        @(negedge clk);
        chk("t1_rsp_off", 32'(rsp_valid), 0);
        chk("t1_hold_data", sx(rsp_data), -15);
        chk("t1_inflight0", 32'(inflight), 0);
        chk("t1_busy0", 32'(busy), 0);

        // both requesters every cycle for 8 cycles
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                int x0, x1;
                x0 = 1000 * (c + 1);
                x1 = -7 * (c + 1) - 1;
                v = 2'b11; a0 = 16'(x0); b0 = 15'd123; a1 = 16'(x1); b1 = 15'd32000;
                exp_id[c] = c % 2;
                exp_p[c]  = (c % 2 == 1) ? x1 * 32000 : x0 * 123;
            end else
                v = '0;
            @(negedge clk);
            chk("t2_ready", 32'(ready), (c < 8) ? ((c % 2 == 1) ? 2 : 1) : 0);
            if (c >= 4) begin
                chk("t2_rsp_valid", 32'(rsp_valid), 1 << exp_id[c-4]);
                chk("t2_rsp_data", sx(rsp_data), exp_p[c-4]);
            end else
                chk("t2_no_rsp", 32'(rsp_valid), 0);
            step();
        end

        // extreme operands
        do_reset();
        en = 1'b1; v = 2'b01; a0 = -16'sd32768; b0 = 15'd32767;
        @(negedge clk);
        chk("t3_ready0", 32'(ready), 1);
        step();
        v = 2'b10; a1 = 16'sd32767; b1 = 15'd32767;
        @(negedge clk);
        chk("t3_ready1", 32'(ready), 2);
        step();
        v = '0;
        step(); step();
        @(negedge clk);
        chk("t3_rsp_valid0", 32'(rsp_valid), 1);
        chk("t3_min_prod", sx(rsp_data), -1073709056);
        step();
        @(negedge clk);
        chk("t3_rsp_valid1", 32'(rsp_valid), 2);
        chk("t3_max_prod", sx(rsp_data), 1073676289);
        step();

        // en dropped with 3 ops in flight
        do_reset();
        en = 1'b1; v = 2'b11; a0 = 16'sd5; b0 = 15'd6; a1 = -16'sd2; b1 = 15'd9;
        step(); step(); step();
        en = 1'b0;
        @(negedge clk);
        chk("t4_ready_off", 32'(ready), 0);
        chk("t4_inflight3", 32'(inflight), 3);
        step();
        for (int c = 4; c < 7; c++) begin
            @(negedge clk);
            chk("t4_rsp_valid", 32'(rsp_valid), (c == 5) ? 2 : 1);
            chk("t4_rsp_data", sx(rsp_data), (c == 5) ? -18 : 30);
            chk("t4_busy", 32'(busy), 1);
            step();
        end
        @(negedge clk);
        chk("t4_busy_fall", 32'(busy), 0);
        chk("t4_rsp_off", 32'(rsp_valid), 0);
        v = '0;

        // reset mid-stream with 4 ops in flight
        do_reset();
        en = 1'b1; v = 2'b11; a0 = 16'sd11; b0 = 15'd3; a1 = 16'sd4; b1 = 15'd7;
        step(); step(); step(); step();
        v = '0;
        @(negedge clk);
        chk("t5_inflight4", 32'(inflight), 4);
        chk("t5_rsp_pre", 32'(rsp_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rsp_clr", 32'(rsp_valid), 0);
        chk("t5_data_clr", 32'(rsp_data), 0);
        chk("t5_inflight_clr", 32'(inflight), 0);
        chk("t5_busy_clr", 32'(busy), 0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_no_rsp", 32'(rsp_valid), 0);
            step();
        end

        // NREQ=3 wrap from ptr=2
        do_reset();
        v3 = 3'b010;
        @(negedge clk);
        chk("t6_ready_r1", 32'(ready3), 3'b010);
        step();
        v3 = 3'b001;
        @(negedge clk);
        chk("t6_wrap_r0", 32'(ready3), 3'b001);
        step();
        v3 = 3'b101;
        @(negedge clk);
        chk("t6_ptr1", 32'(ready3), 3'b100);
        step();
        v3 = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
